// File: rtl/pipelined_barrel_shifter_if.sv
// rtl/pipelined_barrel_shifter_if.sv - operand/result handshake bundle for the pipelined barrel shifter
interface pipelined_barrel_shifter_if #(
  parameter int N = 16,
  parameter int S = $clog2(N)
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [S-1:0] in_shamt;
  logic [1:0]   in_mode;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_zero;

  modport master (
    output in_valid, in_data, in_shamt, in_mode, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );

  modport slave (
    input  in_valid, in_data, in_shamt, in_mode, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - log-depth pipelined barrel shifter (SLL/SRL/SRA/ROL) with valid/ready
module pipelined_barrel_shifter #(
  parameter int N = 16,
  localparam int S = $clog2(N)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  pipelined_barrel_shifter_if.slave bus
);

  localparam logic [1:0] MODE_SLL = 2'b00;
  localparam logic [1:0] MODE_SRL = 2'b01;
  localparam logic [1:0] MODE_SRA = 2'b10;
  localparam logic [1:0] MODE_ROL = 2'b11;

  if (N < 4 || (N & (N - 1)) != 0) begin : g_bad_width
    $error("pipelined_barrel_shifter: N must be a power of two and at least 4");
  end

  // Entry 0 captures the operand; entry k (1..S) holds the result after shifting by 2^(k-1).
  logic [N-1:0] stg_data  [S+1];
  logic         stg_valid [S+1];
  logic [S-1:0] stg_shamt [S];
  logic [1:0]   stg_mode  [S];
  logic         stg_sign  [S];
  logic [N-1:0] nxt_data  [1:S];
  logic         zero_q;
  logic         advance;

  function automatic logic [N-1:0] shift_step(input logic [N-1:0] d, input logic [1:0] mode,
                                              input logic sign, input int amt);
    logic [N-1:0] fill;
    // SRA fills from the original operand's sign, carried down the pipe with the data.
    fill = sign ? ~({N{1'b1}} >> amt) : '0;
    case (mode)
      MODE_SLL: shift_step = d << amt;
      MODE_SRL: shift_step = d >> amt;
      MODE_SRA: shift_step = (d >> amt) | fill;
      MODE_ROL: shift_step = (d << amt) | (d >> (N - amt));
      default:  shift_step = d;
    endcase
  endfunction

  always_comb begin
    for (int k = 1; k <= S; k++) begin
      nxt_data[k] = stg_shamt[k-1][k-1]
                  ? shift_step(stg_data[k-1], stg_mode[k-1], stg_sign[k-1], 1 << (k - 1))
                  : stg_data[k-1];
    end
  end

  assign advance       = ~stg_valid[S] | bus.out_ready;
  assign bus.in_ready  = advance;
  assign bus.out_valid = stg_valid[S];
  assign bus.out_data  = stg_data[S];
  assign bus.out_zero  = zero_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k <= S; k++) begin
        stg_valid[k] <= 1'b0;
        stg_data[k]  <= '0;
      end
      for (int k = 0; k < S; k++) begin
        stg_shamt[k] <= '0;
        stg_mode[k]  <= 2'b00;
        stg_sign[k]  <= 1'b0;
      end
      zero_q <= 1'b0;
    end else if (advance) begin
      stg_valid[0] <= bus.in_valid;
      stg_data[0]  <= bus.in_data;
      stg_shamt[0] <= bus.in_shamt;
      stg_mode[0]  <= bus.in_mode;
      stg_sign[0]  <= bus.in_data[N-1];
      for (int k = 1; k <= S; k++) begin
        stg_valid[k] <= stg_valid[k-1];
        stg_data[k]  <= nxt_data[k];
      end
      for (int k = 1; k < S; k++) begin
        stg_shamt[k] <= stg_shamt[k-1];
        stg_mode[k]  <= stg_mode[k-1];
        stg_sign[k]  <= stg_sign[k-1];
      end
      zero_q <= ~|nxt_data[S];
    end
  end

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - randomized and directed self-checking bench for pipelined_barrel_shifter
module tb_pipelined_barrel_shifter;
  localparam int N = 16;
  localparam int S = 4;

  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;
  int   bp_base = 0;
  logic saw_stall = 1'b0;
  logic held_valid = 1'b0;
  logic [N-1:0] held_data;
  logic held_zero;
  logic [N-1:0] e;
  logic [N-1:0] exp_q[$];
  logic [N-1:0] got_data[$];
  int   got_cyc[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pipelined_barrel_shifter_if #(.N(N)) bus();
  pipelined_barrel_shifter #(.N(N)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model(input logic [1:0] m, input logic [N-1:0] d, input int s);
    logic signed [N-1:0] sd;
    case (m)
      2'd0: model = d << s;
      2'd1: model = d >> s;
      2'd2: begin sd = d; model = sd >>> s; end
      default: model = (s == 0) ? d : ((d << s) | (d >> (N - s)));
    endcase
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: bus.out_ready = 1'b1;
        1: bus.out_ready = ($urandom_range(0, 3) != 0);
        2: bus.out_ready = !((cyc - bp_base) >= 5 && (cyc - bp_base) <= 7);
        default: bus.out_ready = 1'b0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (!rst_n) begin
      held_valid = 1'b0;
    end else begin
      check("in_ready_rule", bus.in_ready, (!bus.out_valid) || bus.out_ready);
      if (held_valid) begin
        check("hold_valid", bus.out_valid, 1);
        check("hold_data", bus.out_data, held_data);
        check("hold_zero", bus.out_zero, held_zero);
      end
      if (bus.out_valid && !bus.out_ready && !bus.in_ready) saw_stall = 1'b1;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("spurious_result", bus.out_valid, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", bus.out_data, e);
          check("out_zero", bus.out_zero, e == '0);
          got_data.push_back(bus.out_data);
          got_cyc.push_back(cyc);
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(bus.in_mode, bus.in_data, int'(bus.in_shamt)));
      held_valid = bus.out_valid && !bus.out_ready;
      held_data  = bus.out_data;
      held_zero  = bus.out_zero;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic [1:0] m, input logic [N-1:0] d, input logic [S-1:0] s);
    logic acc;
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_data  = d;
    bus.in_shamt = s;
    do begin
      @(negedge clk);
      acc = bus.in_ready;
      @(posedge clk);
      #1;
      guard++;
    end while (!acc && guard < 200);
    if (!acc) check("send_timeout", acc, 1);
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (exp_q.size() != 0 && guard < 400) begin
      tick(1);
      guard++;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic single_op(input string tag, input logic [1:0] m, input logic [N-1:0] d,
                           input logic [S-1:0] s, input logic [N-1:0] exp);
    int t0;
    int guard = 0;
    drain();
    send(m, d, s);
    t0 = cyc;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.out_valid && guard < 20);
    check({tag, "_latency"}, cyc - t0, S);
    check({tag, "_data"}, bus.out_data, exp);
    check({tag, "_zero"}, bus.out_zero, exp == '0);
    tick(1);
  endtask

  initial begin
    logic [N-1:0] ev;
    logic [N-1:0] b2b_exp [4];
    int guard;
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_shamt = '0;
    bus.in_mode = 2'b00;
    bus.out_ready = 1'b1;
    tick(3);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_zero", bus.out_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    check("in_ready_after_reset", bus.in_ready, 1);

    single_op("sll_15", 2'd0, 16'h0001, 4'd15, 16'h8000);
    single_op("sra_neg4", 2'd2, 16'h8000, 4'd4, 16'hF800);
    single_op("sra_pos15", 2'd2, 16'h7FFF, 4'd15, 16'h0000);
    single_op("sra_neg15", 2'd2, 16'h8001, 4'd15, 16'hFFFF);
    single_op("srl_12", 2'd1, 16'hF000, 4'd12, 16'h000F);
    single_op("rol_1", 2'd3, 16'h8001, 4'd1, 16'h0003);
    single_op("rol_0", 2'd3, 16'h1234, 4'd0, 16'h1234);
    single_op("sll_0", 2'd0, 16'hA5C3, 4'd0, 16'hA5C3);

    drain();
    got_data.delete();
    got_cyc.delete();
    send(2'd0, 16'h0001, 4'd15);
    send(2'd2, 16'h8000, 4'd4);
    send(2'd1, 16'hF000, 4'd12);
    send(2'd3, 16'h8001, 4'd1);
    drain();
    b2b_exp[0] = 16'h8000;
    b2b_exp[1] = 16'hF800;
    b2b_exp[2] = 16'h000F;
    b2b_exp[3] = 16'h0003;
    check("b2b_count", got_data.size(), 4);
    for (int i = 0; i < 4 && i < got_data.size(); i++) begin
      check("b2b_data", got_data[i], b2b_exp[i]);
      check("b2b_cycle", got_cyc[i] - got_cyc[0], i);
    end

    got_data.delete();
    got_cyc.delete();
    saw_stall = 1'b0;
    bp_base = cyc;
    ready_mode = 2;
    for (int i = 0; i < 6; i++) send(2'd0, 16'h0001, S'(i));
    drain();
    ready_mode = 0;
    check("bp_stall_seen", saw_stall, 1);
    check("bp_count", got_data.size(), 6);
    for (int i = 0; i < 6 && i < got_data.size(); i++) begin
      ev = 16'h0001 << i;
      check("bp_data", got_data[i], ev);
    end

    tick(2);
    got_data.delete();
    got_cyc.delete();
    send(2'd0, 16'h0003, 4'd1);
    tick(1);
    send(2'd1, 16'h0080, 4'd2);
    drain();
    check("bubble_count", got_data.size(), 2);
    if (got_data.size() == 2) begin
      check("bubble_gap", got_cyc[1] - got_cyc[0], 2);
      check("bubble_d0", got_data[0], 16'h0006);
      check("bubble_d1", got_data[1], 16'h0020);
    end

    ready_mode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) tick(1);
      send(2'($urandom), N'($urandom), S'($urandom_range(0, N - 1)));
    end
    drain();
    ready_mode = 0;

    tick(2);
    ready_mode = 3;
    send(2'd0, 16'h0001, 4'd1);
    send(2'd1, 16'h8000, 4'd3);
    send(2'd3, 16'h00F0, 4'd8);
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while (!bus.out_valid && guard < 20);
    check("rst_mid_valid_before", bus.out_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_mid_out_valid", bus.out_valid, 0);
    check("rst_mid_out_data", bus.out_data, 0);
    check("rst_mid_out_zero", bus.out_zero, 0);
    exp_q.delete();
    got_data.delete();
    got_cyc.delete();
    ready_mode = 0;
    tick(2);
    @(negedge clk);
    rst_n = 1'b1;
    tick(10);
    check("rst_no_stale", got_data.size(), 0);
    single_op("rst_srl_8", 2'd1, 16'h0F00, 4'd8, 16'h000F);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, fully pipelined log-depth barrel shifter; successor to the combinational 16-bit left-only shifter.
- Adds four shift modes, a registered stage per shift-amount bit and a valid/ready handshake with backpressure.
- Sits between the ALU operand registers and the result writeback path.
- Accepts one operation per cycle and returns results in order.

Parameters:
- N, 16: data width. Must be a power of two, N >= 4. Elaboration error otherwise.
- S, $clog2(N): shift-amount width and pipeline depth (derived; do not override).

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input operation valid
- in_ready  out  1  block can accept an operation this cycle
- in_data  in  N  operand
- in_shamt  in  S  shift amount, 0..N-1
- in_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROL (rotate left)
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  N  shifted result
- out_zero  out  1  out_data == 0

Behaviour:
- Reset, asynchronous, rst_n low:
  - All stage valid bits, out_valid, out_data and out_zero clear to 0.
  - Data registers clear to 0.
  - in_ready reads 1 after reset deasserts.
  - Reset mid-operation discards all in-flight operations; no result is emitted for them.
- Pipeline structure:
  - Stage k (k = 0..S-1) conditionally shifts by 2^k, controlled by in_shamt bit k.
  - Each stage registers data, the remaining shamt bits, mode and a valid bit.
  - Stage S-1 output drives out_* directly from registers; no combinational path from in_* to out_*.
- Latency: exactly S cycles from an accepted input (in_valid & in_ready at edge t) to out_valid at edge t+S, when out_ready is held high.
- Throughput: 1 operation per cycle.
- Advance and stall:
  - advance = ~out_valid | out_ready.
  - When advance = 1, all stages shift forward together. When advance = 0, every stage register holds.
  - in_ready = advance (combinational). A transfer happens only when in_valid & in_ready.
  - A stage loaded while in_valid = 0 gets valid = 0 (bubble). Bubbles are not collapsed.
- out_valid/out_data stability: once out_valid = 1 and out_ready = 0, out_data, out_zero and out_valid hold stable until a handshake completes.
- Mode rules per stage (shift amount d = 2^k):
  - SLL: vacated LSBs filled with 0.
  - SRL: vacated MSBs filled with 0.
  - SRA: vacated MSBs filled with the sign bit of the original operand (bit N-1 of in_data).
  - ROL: bits leaving the MSB end re-enter at the LSB end.
  - Shifting by stages composes exactly to a single shift by in_shamt.
- Boundaries:
  - in_shamt = 0 passes in_data unchanged in every mode.
  - in_shamt = N-1 is the maximum; out-of-range values are impossible by width.
  - SRA of a negative value by N-1 gives all ones. SRA of a non-negative value by N-1 gives 0.
- Simultaneous events: out_ready and in_valid both high while the pipe is full is a simultaneous pop and push. No data is lost or duplicated.
- out_zero is registered alongside out_data and equals the reduction-NOR of the final result.
- Ordering: results emerge strictly in acceptance order.

Test Plan (N=16, S=4):
- SLL, 0x0001, shamt 15, out_ready=1 -> out_data 0x8000, out_zero 0, out_valid exactly 4 cycles after acceptance.
- SRA, 0x8000, shamt 4 -> 0xF800. SRA, 0x7FFF, shamt 15 -> 0x0000 with out_zero=1. SRL, 0xF000, shamt 12 -> 0x000F.
- ROL, 0x8001, shamt 1 -> 0x0003. ROL, 0x1234, shamt 0 -> 0x1234. Back-to-back issue of all four modes on consecutive cycles -> four results on four consecutive cycles, in order.
- Backpressure: stream 6 SLL ops (0x0001, shamt 0..5) with out_ready low for cycles 5-7 -> in_ready low while out_valid & ~out_ready. Outputs held stable. Sequence 0x0001, 0x0002, ..., 0x0020 delivered with no loss or duplication.
- Bubbles: in_valid toggles 1,0,1 -> out_valid pattern 1,0,1 at S-cycle offset.
- Reset mid-operation: assert rst_n low with 3 ops in flight -> out_valid drops to 0 immediately (asynchronously). After release, no stale results appear and a new op (SRL 0x0F00, shamt 8 -> 0x000F) completes with latency 4.
